// File: rtl/sdram_ram_pkg.sv
// Shared widths and types for the SDRAM core native ram_* request interface.
package sdram_ram_pkg;

  localparam int RAM_ADDR_W = 32;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_LEN_W  = 8;
  localparam int RAM_STRB_W = 4;

  typedef logic [0:0] src_id_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sdram_ram_arb_fifo.sv
// Small register FIFO; remembers which source issued each outstanding beat.
module sdram_ram_arb_fifo #(
  parameter int WIDTH  = 1,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic              accept_o,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [WIDTH-1:0]  data_o
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              do_push;
  logic              do_pop;

  // Fullness comes from the registered count only, so a same-cycle pop never frees space.
  assign accept_o = (count_q != (ADDR_W+1)'(DEPTH));
  assign valid_o  = (count_q != '0);
  assign data_o   = mem_q[rd_ptr_q];
  assign do_push  = push_i & accept_o;
  assign do_pop   = pop_i & valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push)
        wr_ptr_q <= (wr_ptr_q == ADDR_W'(DEPTH-1)) ? '0 : wr_ptr_q + ADDR_W'(1);
      if (do_pop)
        rd_ptr_q <= (rd_ptr_q == ADDR_W'(DEPTH-1)) ? '0 : rd_ptr_q + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push)
      mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sdram_ram_arb2.sv
// Two-source round-robin arbiter for the SDRAM core ram_* port; bursts hold the grant.
//
// state      | meaning
// ARB_IDLE   | no burst open; grant decided combinationally, ties go to the source not last served
// ARB_LOCKED | burst in progress; grant pinned to lock_id_q until beats_q reaches 0 and a beat is taken
module sdram_ram_arb2
  import sdram_ram_pkg::*;
#(
  parameter int TRACK_DEPTH  = 8,
  parameter int TRACK_ADDR_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [RAM_STRB_W-1:0] m0_wr_i,
  input  logic                  m0_rd_i,
  input  logic [RAM_LEN_W-1:0]  m0_len_i,
  input  logic [RAM_ADDR_W-1:0] m0_addr_i,
  input  logic [RAM_DATA_W-1:0] m0_write_data_i,
  output logic                  m0_accept_o,
  output logic                  m0_ack_o,
  output logic                  m0_error_o,
  output logic [RAM_DATA_W-1:0] m0_read_data_o,
  input  logic [RAM_STRB_W-1:0] m1_wr_i,
  input  logic                  m1_rd_i,
  input  logic [RAM_LEN_W-1:0]  m1_len_i,
  input  logic [RAM_ADDR_W-1:0] m1_addr_i,
  input  logic [RAM_DATA_W-1:0] m1_write_data_i,
  output logic                  m1_accept_o,
  output logic                  m1_ack_o,
  output logic                  m1_error_o,
  output logic [RAM_DATA_W-1:0] m1_read_data_o,
  output logic [RAM_STRB_W-1:0] ram_wr_o,
  output logic                  ram_rd_o,
  output logic [RAM_LEN_W-1:0]  ram_len_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic [RAM_DATA_W-1:0] ram_write_data_o,
  input  logic                  ram_accept_i,
  input  logic                  ram_ack_i,
  input  logic                  ram_error_i,
  input  logic [RAM_DATA_W-1:0] ram_read_data_i
);

  arb_state_t           state_q, state_d;
  logic [RAM_LEN_W-1:0] beats_q, beats_d;
  src_id_t              lock_id_q, lock_id_d;
  src_id_t              last_q, last_d;

  logic    req0, req1;
  logic    gnt_valid;
  src_id_t gnt_id;
  logic    fifo_ok;
  logic    issue;
  logic    beat_acc;
  logic    head_valid;
  src_id_t head_id;
  logic    ack_fire;

  logic [RAM_STRB_W-1:0] sel_wr;
  logic                  sel_rd;
  logic [RAM_LEN_W-1:0]  sel_len;
  logic [RAM_ADDR_W-1:0] sel_addr;
  logic [RAM_DATA_W-1:0] sel_data;

  assign req0 = (m0_wr_i != '0) | m0_rd_i;
  assign req1 = (m1_wr_i != '0) | m1_rd_i;

  // Qualifying with rst_ni keeps every output at 0 for the whole reset window.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    if (rst_ni) begin
      if (state_q == ARB_LOCKED) begin
        gnt_id    = lock_id_q;
        gnt_valid = (lock_id_q == 1'b1) ? req1 : req0;
      end else if (req0 && req1) begin
        gnt_valid = 1'b1;
        gnt_id    = ~last_q;
      end else if (req0) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (req1) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  assign sel_wr   = (gnt_id == 1'b1) ? m1_wr_i         : m0_wr_i;
  assign sel_rd   = (gnt_id == 1'b1) ? m1_rd_i         : m0_rd_i;
  assign sel_len  = (gnt_id == 1'b1) ? m1_len_i        : m0_len_i;
  assign sel_addr = (gnt_id == 1'b1) ? m1_addr_i       : m0_addr_i;
  assign sel_data = (gnt_id == 1'b1) ? m1_write_data_i : m0_write_data_i;

  assign issue    = gnt_valid & fifo_ok;
  assign beat_acc = issue & ram_accept_i;

  assign ram_wr_o         = issue ? sel_wr   : '0;
  assign ram_rd_o         = issue & sel_rd;
  assign ram_len_o        = issue ? sel_len  : '0;
  assign ram_addr_o       = issue ? sel_addr : '0;
  assign ram_write_data_o = issue ? sel_data : '0;

  assign m0_accept_o = beat_acc & (gnt_id == 1'b0);
  assign m1_accept_o = beat_acc & (gnt_id == 1'b1);

  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    lock_id_d = lock_id_q;
    last_d    = last_q;
    if (beat_acc) begin
      if (state_q == ARB_IDLE) begin
        if (sel_len != '0) begin
          state_d   = ARB_LOCKED;
          beats_d   = sel_len - RAM_LEN_W'(1);
          lock_id_d = gnt_id;
        end else begin
          last_d = gnt_id;
        end
      end else if (beats_q == '0) begin
        state_d = ARB_IDLE;
        last_d  = lock_id_q;
      end else begin
        beats_d = beats_q - RAM_LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ARB_IDLE;
      beats_q   <= '0;
      lock_id_q <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      beats_q   <= beats_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
    end
  end

  sdram_ram_arb_fifo #(
    .WIDTH  (1),
    .DEPTH  (TRACK_DEPTH),
    .ADDR_W (TRACK_ADDR_W)
  ) u_track (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (beat_acc),
    .data_i   (gnt_id),
    .accept_o (fifo_ok),
    .pop_i    (ram_ack_i & rst_ni),
    .valid_o  (head_valid),
    .data_o   (head_id)
  );

  // An ack with nothing outstanding is dropped rather than routed anywhere.
  assign ack_fire = ram_ack_i & head_valid & rst_ni;

  assign m0_ack_o   = ack_fire & (head_id == 1'b0);
  assign m1_ack_o   = ack_fire & (head_id == 1'b1);
  assign m0_error_o = m0_ack_o & ram_error_i;
  assign m1_error_o = m1_ack_o & ram_error_i;

  assign m0_read_data_o = rst_ni ? ram_read_data_i : '0;
  assign m1_read_data_o = rst_ni ? ram_read_data_i : '0;

  a_ack_with_empty_track: assert property (
    @(posedge clk_i) disable iff (!rst_ni) ram_ack_i |-> head_valid
  );

endmodule

// File: tb/tb_sdram_ram_arb2.sv
// Directed bench for the two-source SDRAM request arbiter.
module tb_sdram_ram_arb2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  m0_wr_i, m1_wr_i;
  logic        m0_rd_i, m1_rd_i;
  logic [7:0]  m0_len_i, m1_len_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic [31:0] m0_write_data_i, m1_write_data_i;
  logic        m0_accept_o, m1_accept_o;
  logic        m0_ack_o, m1_ack_o;
  logic        m0_error_o, m1_error_o;
  logic [31:0] m0_read_data_o, m1_read_data_o;
  logic [3:0]  ram_wr_o;
  logic        ram_rd_o;
  logic [7:0]  ram_len_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_write_data_o;
  logic        ram_accept_i;
  logic        ram_ack_i;
  logic        ram_error_i;
  logic [31:0] ram_read_data_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  sdram_ram_arb2 dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .m0_wr_i          (m0_wr_i),
    .m0_rd_i          (m0_rd_i),
    .m0_len_i         (m0_len_i),
    .m0_addr_i        (m0_addr_i),
    .m0_write_data_i  (m0_write_data_i),
    .m0_accept_o      (m0_accept_o),
    .m0_ack_o         (m0_ack_o),
    .m0_error_o       (m0_error_o),
    .m0_read_data_o   (m0_read_data_o),
    .m1_wr_i          (m1_wr_i),
    .m1_rd_i          (m1_rd_i),
    .m1_len_i         (m1_len_i),
    .m1_addr_i        (m1_addr_i),
    .m1_write_data_i  (m1_write_data_i),
    .m1_accept_o      (m1_accept_o),
    .m1_ack_o         (m1_ack_o),
    .m1_error_o       (m1_error_o),
    .m1_read_data_o   (m1_read_data_o),
    .ram_wr_o         (ram_wr_o),
    .ram_rd_o         (ram_rd_o),
    .ram_len_o        (ram_len_o),
    .ram_addr_o       (ram_addr_o),
    .ram_write_data_o (ram_write_data_o),
    .ram_accept_i     (ram_accept_i),
    .ram_ack_i        (ram_ack_i),
    .ram_error_i      (ram_error_i),
    .ram_read_data_i  (ram_read_data_i)
  );

  task automatic clear_inputs();
    m0_wr_i = '0; m0_rd_i = 1'b0; m0_len_i = '0; m0_addr_i = '0; m0_write_data_i = '0;
    m1_wr_i = '0; m1_rd_i = 1'b0; m1_len_i = '0; m1_addr_i = '0; m1_write_data_i = '0;
    ram_accept_i = 1'b0; ram_ack_i = 1'b0; ram_error_i = 1'b0; ram_read_data_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    m0_rd_i = 1'b1; m0_addr_i = 32'h55; ram_accept_i = 1'b1;
    ram_read_data_i = 32'hFFFF_FFFF;
    #1;
    total++;
    if ({m0_accept_o, m1_accept_o, ram_rd_o, m0_ack_o, m1_ack_o} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {m0_accept_o, m1_accept_o, ram_rd_o, m0_ack_o, m1_ack_o});
    end
    total++;
    if (ram_addr_o !== 32'h0 || m0_read_data_o !== 32'h0) begin
      bad++; $display("FAIL reset_data: addr %h rdata %h want 0", ram_addr_o, m0_read_data_o);
    end
    @(negedge clk_i);
    clear_inputs();
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    total++;
    if ({ram_wr_o, ram_rd_o, m0_accept_o, m1_accept_o} !== 7'b0) begin
      bad++; $display("FAIL reset_idle: got %b want 0", {ram_wr_o, ram_rd_o, m0_accept_o, m1_accept_o});
    end
    @(negedge clk_i);
  endtask

  task automatic test_single();
    clear_inputs();
    m0_rd_i = 1'b1; m0_len_i = 8'd3; ram_accept_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_addr_i = 32'h100 + 32'(4 * i);
      #1;
      total++;
      if ({m0_accept_o, m1_accept_o, ram_rd_o} !== 3'b101) begin
        bad++; $display("FAIL single_accept beat %0d: got %b want 101", i, {m0_accept_o, m1_accept_o, ram_rd_o});
      end
      total++;
      if (ram_addr_o !== 32'h100 + 32'(4 * i) || ram_len_o !== 8'd3) begin
        bad++; $display("FAIL single_addr beat %0d: got %h/%0d want %h/3", i, ram_addr_o, ram_len_o, 32'h100 + 32'(4 * i));
      end
      @(negedge clk_i);
    end
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      ram_ack_i = 1'b1;
      ram_read_data_i = 32'hD000 + 32'(i);
      ram_error_i = (i == 3);
      #1;
      total++;
      if ({m0_ack_o, m1_ack_o, m0_error_o, m1_error_o} !== {2'b10, (i == 3), 1'b0}) begin
        bad++; $display("FAIL single_ack %0d: got %b want %b", i, {m0_ack_o, m1_ack_o, m0_error_o, m1_error_o}, {2'b10, (i == 3), 1'b0});
      end
      total++;
      if (m0_read_data_o !== 32'hD000 + 32'(i)) begin
        bad++; $display("FAIL single_rdata %0d: got %h want %h", i, m0_read_data_o, 32'hD000 + 32'(i));
      end
      @(negedge clk_i);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_wr_i = 4'hF; m0_addr_i = 32'hA0; m0_write_data_i = 32'h1111;
    m1_wr_i = 4'h3; m1_addr_i = 32'hB0; m1_write_data_i = 32'h2222;
    ram_accept_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({m0_accept_o, m1_accept_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL rr_grant %0d: got %b want %b", i, {m0_accept_o, m1_accept_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      total++;
      if (ram_addr_o !== ((i % 2 == 0) ? 32'hA0 : 32'hB0) || ram_wr_o !== ((i % 2 == 0) ? 4'hF : 4'h3)
          || ram_write_data_o !== ((i % 2 == 0) ? 32'h1111 : 32'h2222)) begin
        bad++; $display("FAIL rr_mux %0d: got %h/%h/%h", i, ram_addr_o, ram_wr_o, ram_write_data_o);
      end
      @(negedge clk_i);
    end
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      ram_ack_i = 1'b1;
      #1;
      total++;
      if ({m0_ack_o, m1_ack_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL rr_ack %0d: got %b want %b", i, {m0_ack_o, m1_ack_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      @(negedge clk_i);
    end
    clear_inputs();
  endtask

  task automatic test_burst_lock();
    clear_inputs();
    m0_rd_i = 1'b1; m0_len_i = 8'd7; m1_addr_i = 32'h300; ram_accept_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      m0_addr_i = 32'h200 + 32'(4 * i);
      m1_rd_i = (i >= 2);
      ram_ack_i = (i >= 1);
      #1;
      total++;
      if ({m0_accept_o, m1_accept_o} !== ((i < 8) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL lock_grant %0d: got %b want %b", i, {m0_accept_o, m1_accept_o}, (i < 8) ? 2'b10 : 2'b01);
      end
      if (i >= 1) begin
        total++;
        if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
          bad++; $display("FAIL lock_ack %0d: got %b want 10", i, {m0_ack_o, m1_ack_o});
        end
      end
      @(negedge clk_i);
    end
    clear_inputs();
    ram_ack_i = 1'b1;
    #1;
    total++;
    if ({m0_ack_o, m1_ack_o} !== 2'b01) begin
      bad++; $display("FAIL lock_ack_m1: got %b want 01", {m0_ack_o, m1_ack_o});
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_backpressure();
    clear_inputs();
    m1_rd_i = 1'b1; m1_len_i = 8'd3; m1_addr_i = 32'h400; ram_accept_i = 1'b1;
    #1;
    total++;
    if ({m0_accept_o, m1_accept_o} !== 2'b01) begin
      bad++; $display("FAIL bp_first: got %b want 01", {m0_accept_o, m1_accept_o});
    end
    @(negedge clk_i);
    m0_rd_i = 1'b1; m0_addr_i = 32'h500; m1_addr_i = 32'h404; ram_accept_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({m0_accept_o, m1_accept_o, ram_rd_o} !== 3'b001 || ram_addr_o !== 32'h404) begin
        bad++; $display("FAIL bp_stall %0d: got %b addr %h want 001 addr 404", i, {m0_accept_o, m1_accept_o, ram_rd_o}, ram_addr_o);
      end
      @(negedge clk_i);
    end
    ram_accept_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      m1_addr_i = 32'h404 + 32'(4 * j);
      #1;
      total++;
      if ({m0_accept_o, m1_accept_o} !== 2'b01 || ram_addr_o !== 32'h404 + 32'(4 * j)) begin
        bad++; $display("FAIL bp_resume %0d: got %b addr %h want 01", j, {m0_accept_o, m1_accept_o}, ram_addr_o);
      end
      @(negedge clk_i);
    end
    #1;
    total++;
    if ({m0_accept_o, m1_accept_o} !== 2'b10 || ram_addr_o !== 32'h500) begin
      bad++; $display("FAIL bp_release: got %b addr %h want 10 addr 500", {m0_accept_o, m1_accept_o}, ram_addr_o);
    end
    @(negedge clk_i);
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      ram_ack_i = 1'b1;
      #1;
      total++;
      if ({m0_ack_o, m1_ack_o} !== ((i < 4) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL bp_ack %0d: got %b want %b", i, {m0_ack_o, m1_ack_o}, (i < 4) ? 2'b01 : 2'b10);
      end
      @(negedge clk_i);
    end
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    clear_inputs();
    m0_wr_i = 4'hF; ram_accept_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m0_addr_i = 32'h600 + 32'(4 * i);
      #1;
      total++;
      if (m0_accept_o !== 1'b1) begin
        bad++; $display("FAIL full_fill %0d: got %b want 1", i, m0_accept_o);
      end
      @(negedge clk_i);
    end
    #1;
    total++;
    if (m0_accept_o !== 1'b0 || ram_wr_o !== 4'h0 || ram_addr_o !== 32'h0) begin
      bad++; $display("FAIL full_block: acc %b wr %h addr %h want 0", m0_accept_o, ram_wr_o, ram_addr_o);
    end
    @(negedge clk_i);
    ram_ack_i = 1'b1;
    #1;
    total++;
    if ({m0_accept_o, m0_ack_o} !== 2'b01) begin
      bad++; $display("FAIL full_pop_same: got %b want 01", {m0_accept_o, m0_ack_o});
    end
    @(negedge clk_i);
    #1;
    total++;
    if ({m0_accept_o, m0_ack_o} !== 2'b11) begin
      bad++; $display("FAIL full_push_pop: got %b want 11", {m0_accept_o, m0_ack_o});
    end
    @(negedge clk_i);
    ram_ack_i = 1'b0;
    #1;
    total++;
    if (m0_accept_o !== 1'b1) begin
      bad++; $display("FAIL full_refill: got %b want 1", m0_accept_o);
    end
    @(negedge clk_i);
    #1;
    total++;
    if (m0_accept_o !== 1'b0) begin
      bad++; $display("FAIL full_again: got %b want 0", m0_accept_o);
    end
    @(negedge clk_i);
    clear_inputs();
    for (int i = 0; i < 8; i++) begin
      ram_ack_i = 1'b1;
      #1;
      total++;
      if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
        bad++; $display("FAIL full_drain %0d: got %b want 10", i, {m0_ack_o, m1_ack_o});
      end
      @(negedge clk_i);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    m1_rd_i = 1'b1; m1_len_i = 8'd7; ram_accept_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m1_addr_i = 32'h800 + 32'(4 * i);
      #1;
      total++;
      if ({m0_accept_o, m1_accept_o} !== 2'b01) begin
        bad++; $display("FAIL mid_burst %0d: got %b want 01", i, {m0_accept_o, m1_accept_o});
      end
      @(negedge clk_i);
    end
    m0_rd_i = 1'b1; m0_addr_i = 32'h700;
    ram_ack_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    total++;
    if ({m0_accept_o, m1_accept_o, m0_ack_o, m1_ack_o, ram_rd_o} !== 5'b0 || ram_addr_o !== 32'h0) begin
      bad++; $display("FAIL mid_reset_out: got %b addr %h want 0", {m0_accept_o, m1_accept_o, m0_ack_o, m1_ack_o, ram_rd_o}, ram_addr_o);
    end
    @(negedge clk_i);
    ram_ack_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    total++;
    if ({m0_accept_o, m1_accept_o} !== 2'b10 || ram_addr_o !== 32'h700) begin
      bad++; $display("FAIL mid_tie: got %b addr %h want 10 addr 700", {m0_accept_o, m1_accept_o}, ram_addr_o);
    end
    @(negedge clk_i);
    clear_inputs();
    ram_ack_i = 1'b1;
    #1;
    total++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
      bad++; $display("FAIL mid_track_flushed: got %b want 10", {m0_ack_o, m1_ack_o});
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_single();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_fifo_full();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
